// File: rtl/sy_ppl_fp_regfile_mp.sv
// FP register file: 32 x DWTH flops, NaN-boxing, busy scoreboard and FS dirty tracking.
// Reads are combinational with same-cycle write bypass; writes land at the next edge; no backpressure.
module sy_ppl_fp_regfile_mp #(
    parameter int DWTH = 64,
    parameter int NRD  = 3,
    parameter int NWR  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NRD*5-1:0]     rd_idx_i,
    output logic [NRD*DWTH-1:0]  rd_data_o,
    output logic [NRD-1:0]       rd_busy_o,
    input  logic [NWR-1:0]       wr_en_i,
    input  logic [NWR*5-1:0]     wr_idx_i,
    input  logic [NWR*DWTH-1:0]  wr_data_i,
    input  logic [NWR-1:0]       wr_sp_i,
    input  logic                 busy_set_en_i,
    input  logic [4:0]           busy_set_idx_i,
    input  logic                 flush_i,
    output logic                 fs_dirty_o,
    input  logic                 fs_clean_i
);

    // Upper word forced to ones for single-precision results; empty when DWTH=32.
    localparam logic [DWTH-1:0] LO_MASK = DWTH'({32{1'b1}});
    localparam logic [DWTH-1:0] HI_MASK = ~LO_MASK;

    logic [DWTH-1:0] regs_q  [32];
    logic [DWTH-1:0] regs_d  [32];
    logic [31:0]     busy_q;
    logic [31:0]     busy_d;
    logic [31:0]     wr_hit;
    logic            fs_dirty_q;
    logic [DWTH-1:0] wr_boxed [NWR];
    logic [NRD-1:0]  rd_hit;

    always_comb begin
        for (int w = 0; w < NWR; w++) begin
            wr_boxed[w] = wr_data_i[w*DWTH +: DWTH];
            if (wr_sp_i[w]) begin
                wr_boxed[w] = wr_data_i[w*DWTH +: DWTH] | HI_MASK;
            end
        end
    end

    // Ascending port scan: the youngest matching writer is applied last and wins.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            regs_d[i] = regs_q[i];
            wr_hit[i] = 1'b0;
            for (int w = 0; w < NWR; w++) begin
                if (wr_en_i[w] && (wr_idx_i[w*5 +: 5] == 5'(i))) begin
                    regs_d[i] = wr_boxed[w];
                    wr_hit[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            if (flush_i) begin
                busy_d[i] = 1'b0;
            end else if (busy_set_en_i && (busy_set_idx_i == 5'(i))) begin
                busy_d[i] = 1'b1;
            end else if (wr_hit[i]) begin
                busy_d[i] = 1'b0;
            end else begin
                busy_d[i] = busy_q[i];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NRD; r++) begin
            rd_data_o[r*DWTH +: DWTH] = regs_q[rd_idx_i[r*5 +: 5]];
            rd_hit[r] = 1'b0;
            for (int w = 0; w < NWR; w++) begin
                if (wr_en_i[w] && (wr_idx_i[w*5 +: 5] == rd_idx_i[r*5 +: 5])) begin
                    rd_data_o[r*DWTH +: DWTH] = wr_boxed[w];
                    rd_hit[r] = 1'b1;
                end
            end
            // A same-cycle writeback releases the register unless issue re-claims it.
            rd_busy_o[r] = busy_q[rd_idx_i[r*5 +: 5]]
                         & ~(rd_hit[r] & ~(busy_set_en_i && (busy_set_idx_i == rd_idx_i[r*5 +: 5])));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            fs_dirty_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            if (|wr_en_i) begin
                fs_dirty_q <= 1'b1;
            end else if (fs_clean_i) begin
                fs_dirty_q <= 1'b0;
            end
        end
    end

    assign fs_dirty_o = fs_dirty_q;

endmodule

// File: tb/tb_sy_ppl_fp_regfile_mp.sv
// Directed bench for sy_ppl_fp_regfile_mp (DWTH=64, NRD=3, NWR=2).
module tb_sy_ppl_fp_regfile_mp;

    logic         clk = 1'b0;
    logic         rst;
    logic [14:0]  rd_idx;
    logic [191:0] rd_data;
    logic [2:0]   rd_busy;
    logic [1:0]   wr_en;
    logic [9:0]   wr_idx;
    logic [127:0] wr_data;
    logic [1:0]   wr_sp;
    logic         bs_en;
    logic [4:0]   bs_idx;
    logic         flush;
    logic         fs_dirty;
    logic         fs_clean;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sy_ppl_fp_regfile_mp #(.DWTH(64), .NRD(3), .NWR(2)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .rd_idx_i       (rd_idx),
        .rd_data_o      (rd_data),
        .rd_busy_o      (rd_busy),
        .wr_en_i        (wr_en),
        .wr_idx_i       (wr_idx),
        .wr_data_i      (wr_data),
        .wr_sp_i        (wr_sp),
        .busy_set_en_i  (bs_en),
        .busy_set_idx_i (bs_idx),
        .flush_i        (flush),
        .fs_dirty_o     (fs_dirty),
        .fs_clean_i     (fs_clean)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        wr_en = '0; wr_sp = '0; bs_en = 1'b0; flush = 1'b0; fs_clean = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rd_idx = '0; wr_idx = '0; wr_data = '0; bs_idx = '0;
        idle();
        tick(); tick();
        rst = 1'b0;
        rd_idx = {5'd5, 5'd5, 5'd5};
        #1;
        for (int r = 0; r < 3; r++) chk("reset_data", rd_data[r*64 +: 64], 64'h0);
        chk("reset_busy", 64'(rd_busy), 64'h0);
        chk("reset_dirty", 64'(fs_dirty), 64'h0);

        // NaN-boxed single-precision write with same-cycle bypass
        wr_en = 2'b01; wr_idx = {5'd0, 5'd3}; wr_data = {64'h0, 64'h0000_0000_3F80_0000}; wr_sp = 2'b01;
        rd_idx = {5'd5, 5'd5, 5'd3};
        #1;
        chk("sp_bypass", rd_data[63:0], 64'hFFFF_FFFF_3F80_0000);
        tick(); idle(); #1;
        chk("sp_stored", rd_data[63:0], 64'hFFFF_FFFF_3F80_0000);
        chk("dirty_after_wr", 64'(fs_dirty), 64'h1);

        // Two writers, same index: port 1 wins
        wr_en = 2'b11; wr_idx = {5'd7, 5'd7}; wr_data = {64'h22, 64'h11};
        rd_idx = {5'd5, 5'd7, 5'd3};
        #1;
        chk("ww_bypass", rd_data[127:64], 64'h22);
        tick(); idle(); #1;
        chk("ww_stored", rd_data[127:64], 64'h22);

        // Busy: write racing a re-claim keeps busy; lone write clears it
        bs_en = 1'b1; bs_idx = 5'd9; rd_idx = {5'd9, 5'd7, 5'd3};
        tick(); idle(); #1;
        chk("busy_set", 64'(rd_busy[2]), 64'h1);
        bs_en = 1'b1; bs_idx = 5'd9; wr_en = 2'b01; wr_idx = {5'd0, 5'd9}; wr_data = {64'h0, 64'h99};
        #1;
        chk("busy_wr_set_comb", 64'(rd_busy[2]), 64'h1);
        tick(); idle(); #1;
        chk("busy_wr_set_held", 64'(rd_busy[2]), 64'h1);
        wr_en = 2'b10; wr_idx = {5'd9, 5'd0}; wr_data = {64'h5A, 64'h0};
        #1;
        chk("busy_wr_comb", 64'(rd_busy[2]), 64'h0);
        chk("wr_p1_bypass", rd_data[191:128], 64'h5A);
        tick(); idle(); #1;
        chk("busy_wr_clear", 64'(rd_busy[2]), 64'h0);

        // Flush wins over a same-cycle claim
        bs_en = 1'b1; bs_idx = 5'd1; tick();
        bs_idx = 5'd2; tick(); idle();
        rd_idx = {5'd4, 5'd2, 5'd1};
        #1;
        chk("busy_f1_f2", 64'(rd_busy), 64'h3);
        flush = 1'b1; bs_en = 1'b1; bs_idx = 5'd4;
        tick(); idle(); #1;
        chk("flush_busy", 64'(rd_busy), 64'h0);

        // FS dirty: clean alone, write+clean, clean alone
        fs_clean = 1'b1; tick(); idle(); #1;
        chk("clean_alone1", 64'(fs_dirty), 64'h0);
        fs_clean = 1'b1; wr_en = 2'b01; wr_idx = {5'd0, 5'd0}; wr_data = {64'h0, 64'hABC};
        tick(); idle(); #1;
        chk("wr_clean_dirty", 64'(fs_dirty), 64'h1);
        rd_idx = {5'd9, 5'd7, 5'd0};
        #1;
        chk("f0_writable", rd_data[63:0], 64'hABC);
        fs_clean = 1'b1; tick(); idle(); #1;
        chk("clean_alone2", 64'(fs_dirty), 64'h0);

        // Reset overrides concurrent writes and claims
        bs_en = 1'b1; bs_idx = 5'd10; tick(); idle();
        rst = 1'b1; wr_en = 2'b11; wr_idx = {5'd10, 5'd0}; wr_data = {64'h77, 64'h66}; bs_en = 1'b1; bs_idx = 5'd3;
        rd_idx = {5'd10, 5'd7, 5'd0};
        #1;
        chk("rst_bypass", rd_data[191:128], 64'h77);
        tick(); idle(); rst = 1'b0;
        rd_idx = {5'd10, 5'd9, 5'd0};
        #1;
        chk("rst_f0", rd_data[63:0], 64'h0);
        chk("rst_f9", rd_data[127:64], 64'h0);
        chk("rst_f10", rd_data[191:128], 64'h0);
        chk("rst_busy", 64'(rd_busy), 64'h0);
        chk("rst_dirty", 64'(fs_dirty), 64'h0);
        rd_idx = {5'd3, 5'd7, 5'd3};
        #1;
        chk("rst_f3", rd_data[63:0], 64'h0);
        chk("rst_f7", rd_data[127:64], 64'h0);

        // Normal operation straight after reset
        wr_en = 2'b01; wr_idx = {5'd0, 5'd3}; wr_data = {64'h0, 64'h1234};
        tick(); idle(); #1;
        chk("post_rst_wr", rd_data[63:0], 64'h1234);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sy_ppl_fp_regfile_mp.md
SY_PPL_FP_REGFILE_MP -- requirements
Module: sy_ppl_fp_regfile_mp

Interface
REQ-001 SHALL have parameter DWTH, default 64, meaning register data width in bits (64 or 32 only).
REQ-002 SHALL have parameter NRD, default 3, meaning number of combinational read ports (1..4).
REQ-003 SHALL have parameter NWR, default 2, meaning number of write ports (1..3); a higher port index means a younger writer.
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates occur on its rising edge.
REQ-005 SHALL have port rst_i  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port rd_idx_i  input  NRD*5  read register index, 5 bits per port.
REQ-007 SHALL have port rd_data_o  output  NRD*DWTH  read data, DWTH bits per port.
REQ-008 SHALL have port rd_busy_o  output  NRD  per read port: the indexed register still awaits a writeback.
REQ-009 SHALL have port wr_en_i  input  NWR  per write port enable.
REQ-010 SHALL have port wr_idx_i  input  NWR*5  write index, 5 bits per port.
REQ-011 SHALL have port wr_data_i  input  NWR*DWTH  write data, DWTH bits per port.
REQ-012 SHALL have port wr_sp_i  input  NWR  per write port: the result is single-precision and is NaN-boxed.
REQ-013 SHALL have port busy_set_en_i  input  1  issue stage claims a destination register.
REQ-014 SHALL have port busy_set_idx_i  input  5  index of the claimed register.
REQ-015 SHALL have port flush_i  input  1  pipeline flush; clears every busy bit.
REQ-016 SHALL have port fs_dirty_o  output  1  FP state modified since the last clean (feeds mstatus.FS).
REQ-017 SHALL have port fs_clean_i  input  1  CSR write that sets FS to Clean.

Function
REQ-018 SHALL hold 32 registers of DWTH bits each plus 32 busy bits, all as flops.
REQ-019 SHALL, when DWTH=64 and wr_sp_i=1, store {32'hFFFF_FFFF, data[31:0]}; when DWTH=32, wr_sp_i SHALL be ignored.
REQ-020 SHALL, when several enabled write ports target the same index in one cycle, store only the data of the highest-indexed port.
REQ-021 SHALL drive rd_data_o combinationally (zero latency): the NaN-boxed data of the highest enabled write port whose index matches this cycle, otherwise the stored value.
REQ-022 SHALL update the busy bit of each register at each edge, in priority order (highest first): flush_i clears the bit; a matching busy_set_en_i sets it; a matching enabled write clears it; otherwise the bit holds.
REQ-023 SHALL ignore busy_set_en_i in any cycle where flush_i=1; a write in a flush cycle still updates the stored data.
REQ-024 SHALL drive rd_busy_o as the stored busy bit, forced to 0 when a same-cycle enabled write targets that index and busy_set_en_i does not target it.
REQ-025 SHALL set fs_dirty_o at the next edge after any enabled write; it SHALL clear on fs_clean_i; if both occur in one cycle, set SHALL win.
REQ-026 SHALL treat register f0 as an ordinary writable register (no hardwired zero).
REQ-027 SHALL contain no combinational path from rd_idx_i to any state element.

Reset
REQ-028 SHALL, when rst_i=1 at an edge, clear all 32 registers, all busy bits and fs_dirty_o to 0, overriding all same-cycle writes, sets and cleans.
REQ-029 SHALL, during and after reset, drive rd_data_o from the reset values, with same-cycle write bypass still active (REQ-021).
REQ-030 SHALL, at the first edge after rst_i falls, update normally; no warm-up cycles are required.

Verification
REQ-031 SHALL cover: after reset, read f5 on all ports -> rd_data_o=0, rd_busy_o=0, fs_dirty_o=0.
REQ-032 SHALL cover: DWTH=64, port0 writes f3=64'h0000_0000_3F80_0000 with wr_sp_i=1 while reading f3 in the same cycle -> bypass returns 64'hFFFF_FFFF_3F80_0000, and the same value is stored.
REQ-033 SHALL cover: port0 and port1 both write f7 (0x11 and 0x22) -> same-cycle read and next-cycle read both return 0x22.
REQ-034 SHALL cover: busy_set f9, then a write to f9 together with busy_set f9 in one cycle -> f9 remains busy; a later write alone -> busy clears and rd_busy_o=0 in the write cycle.
REQ-035 SHALL cover: busy bits set on f1 and f2, then flush_i together with busy_set f4 -> all busy bits are 0 next cycle.
REQ-036 SHALL cover: a write with fs_clean_i in the same cycle -> fs_dirty_o=1; fs_clean_i alone -> fs_dirty_o=0; rst_i asserted while writes are active -> all state is 0.
